// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin pick of one producer per cycle onto the
// registered regfile write port, with a running count of committed writes.
module wb_arbiter #(
    parameter int NSRC  = 4,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NSRC-1:0]     src_valid,
    input  logic [5*NSRC-1:0]   src_rd,
    input  logic [32*NSRC-1:0]  src_data,
    output logic [NSRC-1:0]     src_ready,
    input  logic                stall,
    output logic                we,
    output logic [4:0]          waddr,
    output logic [31:0]         wdata,
    output logic [1:0]          wb_src,
    output logic [CNT_W-1:0]    wb_cnt
);

    logic [1:0]  ptr;
    logic [1:0]  gnt;
    logic        gnt_vld;
    logic [4:0]  g_rd;
    logic [31:0] g_data;
    logic        g_we;

    // Search starts at ptr and wraps; the first valid producer wins.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt       = 2'd0;
        src_ready = '0;
        for (int k = 0; k < 4; k++) begin
            if (!gnt_vld && src_valid[ptr + 2'(k)]) begin
                gnt_vld = 1'b1;
                gnt     = ptr + 2'(k);
            end
        end
        if (stall || rst) begin
            gnt_vld = 1'b0;
        end
        if (gnt_vld) begin
            src_ready[gnt] = 1'b1;
        end
    end

    assign g_rd   = src_rd[5*int'(gnt) +: 5];
    assign g_data = src_data[32*int'(gnt) +: 32];
    // r0 writes still complete the handshake but never reach the regfile.
    assign g_we   = gnt_vld && (g_rd != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr    <= 2'd0;
            we     <= 1'b0;
            waddr  <= 5'd0;
            wdata  <= 32'd0;
            wb_src <= 2'd0;
            wb_cnt <= '0;
        end else begin
            we <= g_we;
            if (gnt_vld) begin
                ptr    <= gnt + 2'd1;
                waddr  <= g_rd;
                wdata  <= g_data;
                wb_src <= gnt;
            end
            if (g_we) begin
                wb_cnt <= wb_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that drives the single register-file write port, the writer end of the regfile. It collects results from up to four functional-unit producers (ALU, MUL/DIV, LSU, CSR) over valid/ready handshakes and selects one per cycle with round-robin fairness. It presents the winner on a registered `we`/`waddr`/`wdata` port one cycle later. It also keeps a write counter for difftest.

## Interface
Parameters:
- `NSRC`, 4: number of producer channels (fixed at 4 in this revision).
- `CNT_W`, 32: width of the writeback counter.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `src_valid` input 4: bit i high means producer i holds a result.
- `src_rd` input 20: destination register for each producer, 5 bits each; producer i is `[5i+4:5i]`.
- `src_data` input 128: result for each producer, 32 bits each; producer i is `[32i+31:32i]`.
- `src_ready` output 4: one-hot grant; bit i high means producer i's handshake completes this cycle.
- `stall` input 1: when high, no grant is issued this cycle.
- `we` output 1: write enable to the regfile, registered.
- `waddr` output 5: write address, registered.
- `wdata` output 32: write data, registered.
- `wb_src` output 2: index of the producer whose result is currently on the write port.
- `wb_cnt` output CNT_W: count of architectural writes issued; wraps.

## Operation
- State:
  - 2-bit round-robin pointer `ptr`.
  - Output registers `we`, `waddr`, `wdata`, `wb_src`.
  - Counter `wb_cnt`.
- Grant selection (combinational):
  - The search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
  - The first index with `src_valid` set wins, and its `src_ready` bit goes high.
  - No grant is issued if `stall`=1, `rst`=1, or `src_valid`=0.
- Ready depends combinationally on valid. Producers must not make valid depend on ready.
- Once valid is raised, a producer holds valid, rd and data stable until it is granted.
- On a grant to index g:
  - `ptr` <= g+1 mod 4.
  - `waddr` <= src_rd[g], `wdata` <= src_data[g], `wb_src` <= g.
  - `we` <= (src_rd[g] != 0).
- A write to r0 completes its handshake and advances `ptr`. It does not assert `we` and does not increment `wb_cnt`; `waddr` and `wdata` still load.
- With no grant:
  - `we` <= 0.
  - `waddr`, `wdata`, `wb_src` hold their values.
  - `ptr` holds.
- `wb_cnt` increments by 1 on each edge that loads `we`=1. It wraps from 2^CNT_W-1 to 0 with no flag.
- The regfile always accepts a write, so the arbiter has no output backpressure. Throughput is one result per cycle.
- Duplicate rd across producers is not checked. Writes land in grant order, so the later grant wins.

## Timing
- Latency: a grant in cycle N puts the write on the port in cycle N+1. The regfile commits it at the end of N+1 and bypasses it to reads during N+1.
- `we` is high for exactly one cycle per nonzero-rd grant. Back-to-back grants keep `we` high continuously.
- `stall` acts in the same cycle. A stall in cycle N gives `we`=0 in N+1 and leaves `ptr` unchanged.
- Fairness: a continuously valid producer is granted within 4 non-stalled cycles.
- Reset values: `ptr`=0, `we`=0, `waddr`=0, `wdata`=0, `wb_src`=0, `wb_cnt`=0.
- While `rst` is high, `src_ready`=0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
  - A write registered before reset is dropped: `we` falls asynchronously.
  - A producer whose grant coincides with reset assertion has not completed its handshake.
- After reset deasserts, the first grant can occur on the next cycle, with priority starting at producer 0.

## Test plan
- **Single source:** after reset, src_valid=4'b0100, rd[2]=5, data[2]=0xDEADBEEF -> src_ready=4'b0100 in the same cycle; next cycle we=1, waddr=5, wdata=0xDEADBEEF, wb_src=2, wb_cnt=1.
- **Round-robin:**
  - After reset, all four producers are held valid with rd=1..4 -> grants in order 0,1,2,3,0.
  - `we` is high for 5 consecutive cycles, waddr sequence 1,2,3,4,1, and wb_cnt reaches 5.
- **Pointer fairness:** grant producer 3, then assert src_valid=4'b1001 -> producer 0 is granted before producer 3.
- **r0 drop:** producer 1 valid with rd=0, data=0x1234 -> src_ready[1]=1; next cycle we=0, wb_cnt unchanged; the following grant starts its search at index 2.
- **Stall:**
  - stall=1 for 3 cycles with src_valid=4'b1111 -> src_ready=0 and we=0 throughout, ptr held.
  - Drop stall -> producer at ptr is granted the same cycle.
- **Reset mid-stream:**
  - Pulse rst asynchronously while we=1 and wb_cnt=7 -> we, waddr, wdata and wb_cnt drop to 0 before the next edge.
  - After release, producer 0 wins first.
- **Wrap:** force wb_cnt to 0xFFFFFFFF, then one nonzero write -> wb_cnt=0.
